// File: rtl/cordic_phase_gen.sv
// Phase/sample source for the CORDIC rotator: wrapping degree accumulator, quadrant encoding,
// rate-divided sample strobes and a returned-result counter that closes each burst with done.
module cordic_phase_gen #(
    parameter int unsigned DATA_WIDTH  = 16,
    parameter int unsigned PHASE_WIDTH = 32,
    parameter int unsigned CNT_WIDTH   = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start_i,
    input  logic                   stop_i,
    input  logic [PHASE_WIDTH-1:0] phase_init_i,
    input  logic [PHASE_WIDTH-1:0] freq_word_i,
    input  logic [CNT_WIDTH-1:0]   num_samples_i,
    input  logic [7:0]             rate_div_i,
    input  logic [DATA_WIDTH-1:0]  amp_i,
    input  logic                   cordic_valid_i,
    output logic                   en_o,
    output logic [DATA_WIDTH-1:0]  x0_o,
    output logic [DATA_WIDTH-1:0]  y0_o,
    output logic [PHASE_WIDTH-1:0] phase_o,
    output logic                   busy_o,
    output logic                   done_o
);

    localparam int unsigned AccWidth = PHASE_WIDTH + 1;

    typedef logic signed [AccWidth-1:0] acc_t;

    localparam acc_t HalfTurn    = acc_t'(11796480);
    localparam acc_t NegHalfTurn = acc_t'(-11796480);
    localparam acc_t QuarterTurn = acc_t'(5898240);
    localparam acc_t NegQuarter  = acc_t'(-5898240);
    localparam acc_t FullTurn    = acc_t'(23592960);
    localparam acc_t MaxAngle    = acc_t'(11796479);
    localparam acc_t MinAngle    = acc_t'(-11796479);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StWait
    } state_e;

    // Clamp a raw phase word into the open half-turn so a single wrap step always suffices.
    function automatic acc_t sat_angle(input logic [PHASE_WIDTH-1:0] raw);
        acc_t v;
        v = {raw[PHASE_WIDTH-1], raw};
        if (v > MaxAngle) begin
            v = MaxAngle;
        end else if (v < MinAngle) begin
            v = MinAngle;
        end
        return v;
    endfunction

    function automatic acc_t wrap_angle(input acc_t s);
        acc_t v;
        v = s;
        if (v >= HalfTurn) begin
            v = v - FullTurn;
        end else if (v < NegHalfTurn) begin
            v = v + FullTurn;
        end
        return v;
    endfunction

    // Quadrants 00/11 pass the angle through; 01/10 carry the residual relative to +/-90 deg.
    function automatic logic [PHASE_WIDTH-1:0] encode(input acc_t a);
        logic [PHASE_WIDTH-1:0] enc;
        acc_t                   r;
        enc = a[PHASE_WIDTH-1:0];
        r   = '0;
        if (a >= QuarterTurn) begin
            r   = a - QuarterTurn;
            enc = {2'b01, r[PHASE_WIDTH-3:0]};
        end else if (a < NegQuarter) begin
            r   = a + QuarterTurn;
            enc = {2'b10, r[PHASE_WIDTH-3:0]};
        end
        return enc;
    endfunction

    state_e                 state_q, state_d;
    acc_t                   acc_q, acc_d;
    acc_t                   step_q, step_d;
    logic [7:0]             rate_div_q, rate_div_d;
    logic [7:0]             div_cnt_q, div_cnt_d;
    logic [CNT_WIDTH-1:0]   num_q, num_d;
    logic [CNT_WIDTH-1:0]   issued_q, issued_d;
    logic [CNT_WIDTH-1:0]   returned_q, returned_d;
    logic                   en_q, en_d;
    logic [PHASE_WIDTH-1:0] phase_q, phase_d;
    logic [DATA_WIDTH-1:0]  x0_q, x0_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;

    acc_t init_sat;
    acc_t step_sat;
    logic limit_hit;

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        step_d     = step_q;
        rate_div_d = rate_div_q;
        div_cnt_d  = div_cnt_q;
        num_d      = num_q;
        issued_d   = issued_q;
        returned_d = returned_q;
        en_d       = 1'b0;
        phase_d    = phase_q;
        x0_d       = x0_q;
        done_d     = 1'b0;
        init_sat   = sat_angle(phase_init_i);
        step_sat   = sat_angle(freq_word_i);
        limit_hit  = (num_q != '0) && (issued_q == num_q);

        if (state_q != StIdle && cordic_valid_i) begin
            returned_d = returned_q + 1'b1;
        end

        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    state_d    = StRun;
                    step_d     = step_sat;
                    acc_d      = wrap_angle(init_sat + step_sat);
                    phase_d    = encode(init_sat);
                    en_d       = 1'b1;
                    x0_d       = amp_i;
                    rate_div_d = rate_div_i;
                    num_d      = num_samples_i;
                    div_cnt_d  = '0;
                    issued_d   = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
                    returned_d = '0;
                end
            end
            StRun: begin
                // stop and burst completion both take priority over a pending issue
                if (stop_i || limit_hit) begin
                    state_d = StWait;
                end else if (div_cnt_q == rate_div_q) begin
                    en_d      = 1'b1;
                    phase_d   = encode(acc_q);
                    acc_d     = wrap_angle(acc_q + step_q);
                    issued_d  = issued_q + 1'b1;
                    div_cnt_d = '0;
                end else begin
                    div_cnt_d = div_cnt_q + 8'd1;
                end
            end
            StWait: begin
                if (returned_q == issued_q) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            acc_q      <= '0;
            step_q     <= '0;
            rate_div_q <= '0;
            div_cnt_q  <= '0;
            num_q      <= '0;
            issued_q   <= '0;
            returned_q <= '0;
            en_q       <= 1'b0;
            phase_q    <= '0;
            x0_q       <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            step_q     <= step_d;
            rate_div_q <= rate_div_d;
            div_cnt_q  <= div_cnt_d;
            num_q      <= num_d;
            issued_q   <= issued_d;
            returned_q <= returned_d;
            en_q       <= en_d;
            phase_q    <= phase_d;
            x0_q       <= x0_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign en_o    = en_q;
    assign x0_o    = x0_q;
    assign y0_o    = '0;
    assign phase_o = phase_q;
    assign busy_o  = busy_q;
    assign done_o  = done_q;

endmodule
